// File: rtl/a2d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a2d_pkg
// Purpose  : Shared types and channel constants for the A2D round-robin sched.
// Revision : 1.0
// ============================================================================
package a2d_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEL       = 3'd1,
      WAIT_SEL  = 3'd2,
      CONV      = 3'd3,
      WAIT_CONV = 3'd4
   } a2d_state_t;

   localparam logic [2:0] CH_LFT   = 3'd0;
   localparam logic [2:0] CH_RGHT  = 3'd4;
   localparam logic [2:0] CH_STEER = 3'd5;
   localparam logic [2:0] CH_BATT  = 3'd6;

   localparam logic [1:0] IDX_LFT   = 2'd0;
   localparam logic [1:0] IDX_RGHT  = 2'd1;
   localparam logic [1:0] IDX_STEER = 2'd2;
   localparam logic [1:0] IDX_BATT  = 2'd3;

   function automatic logic [2:0] ch_of_idx(input logic [1:0] idx);
      logic [2:0] ch;
      case (idx)
         IDX_LFT:   ch = CH_LFT;
         IDX_RGHT:  ch = CH_RGHT;
         IDX_STEER: ch = CH_STEER;
         default:   ch = CH_BATT;
      endcase
      return ch;
   endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_period_tmr.sv
`default_nettype none
// ============================================================================
// Module   : a2d_period_tmr
// Purpose  : Free-running round timer; one-cycle tick on all-ones wrap.
// Revision : 1.0
// ============================================================================
module a2d_period_tmr #(
   parameter int FAST_SIM = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int              C_WIDTH = (FAST_SIM != 0) ? 10 : 16;
   localparam logic [C_WIDTH-1:0] C_ONE = {{(C_WIDTH-1){1'b0}}, 1'b1};

   logic [C_WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= r_cnt + C_ONE;
   end

   assign tick = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/a2d_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : a2d_rr_sched
// Purpose  : Round-robin SPI A2D sequencer for load cells, steer pot, battery.
// Revision : 1.0
// ============================================================================
module a2d_rr_sched #(
   parameter int FAST_SIM = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        ld_vld,
   output logic        ovr
);
   import a2d_pkg::*;

   a2d_state_t  r_state, w_state_nxt;
   logic [1:0]  r_ch_idx;
   logic        w_tick;
   logic        w_wrt_nxt;
   logic        w_latch;
   logic        w_done_ok;
   logic        r_spi_wrt;
   logic [15:0] r_spi_cmd;
   logic [11:0] r_lft, r_rght, r_steer, r_batt;
   logic        r_rght_upd;
   logic        r_ld_vld;
   logic        r_ovr;
   logic        w_unused;

   assign w_unused = ^spi_rd[15:12];

   a2d_period_tmr #(.FAST_SIM(FAST_SIM)) u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   // The monarch cannot finish in the cycle it is started, so a done
   // coincident with our own wrt is treated as stray.
   assign w_done_ok = spi_done & ~r_spi_wrt;

   always_comb begin
      w_state_nxt = r_state;
      w_wrt_nxt   = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         IDLE:      if (w_tick) w_state_nxt = SEL;
         SEL: begin
            w_wrt_nxt   = 1'b1;
            w_state_nxt = WAIT_SEL;
         end
         WAIT_SEL:  if (w_done_ok) w_state_nxt = CONV;
         CONV: begin
            w_wrt_nxt   = 1'b1;
            w_state_nxt = WAIT_CONV;
         end
         WAIT_CONV: begin
            if (w_done_ok) begin
               w_latch     = 1'b1;
               w_state_nxt = (r_ch_idx == IDX_BATT) ? IDLE : SEL;
            end
         end
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ch_idx   <= 2'd0;
         r_spi_wrt  <= 1'b0;
         r_spi_cmd  <= 16'h0000;
         r_rght_upd <= 1'b0;
         r_ld_vld   <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_spi_wrt  <= w_wrt_nxt;
         if (w_wrt_nxt) r_spi_cmd <= {2'b00, ch_of_idx(r_ch_idx), 11'h000};
         if (w_latch)   r_ch_idx  <= r_ch_idx + 2'd1;
         r_rght_upd <= w_latch && (r_ch_idx == IDX_RGHT);
         r_ld_vld   <= r_rght_upd;
         if (w_tick && (r_state != IDLE)) r_ovr <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lft   <= 12'h000;
         r_rght  <= 12'h000;
         r_steer <= 12'h000;
         r_batt  <= 12'h000;
      end else if (w_latch) begin
         case (r_ch_idx)
            IDX_LFT:   r_lft   <= spi_rd[11:0];
            IDX_RGHT:  r_rght  <= spi_rd[11:0];
            IDX_STEER: r_steer <= spi_rd[11:0];
            default:   r_batt  <= spi_rd[11:0];
         endcase
      end
   end

   assign spi_wrt   = r_spi_wrt;
   assign spi_cmd   = r_spi_cmd;
   assign lft_ld    = r_lft;
   assign rght_ld   = r_rght;
   assign steer_pot = r_steer;
   assign batt      = r_batt;
   assign ld_vld    = r_ld_vld;
   assign ovr       = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_a2d_rr_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_a2d_rr_sched
// Purpose  : Directed scoreboard bench with a behavioural SPI monarch model.
// Revision : 1.0
// ============================================================================
module tb_a2d_rr_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_done = 1'b0;
   logic [15:0] spi_rd = 16'h0000;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic [11:0] lft_ld, rght_ld, steer_pot, batt;
   logic        ld_vld, ovr;

   a2d_rr_sched #(.FAST_SIM(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_wrt   (spi_wrt),
      .spi_cmd   (spi_cmd),
      .spi_done  (spi_done),
      .spi_rd    (spi_rd),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .steer_pot (steer_pot),
      .batt      (batt),
      .ld_vld    (ld_vld),
      .ovr       (ovr)
   );

   always #10 clk = ~clk;

   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc = 0;
   int  done_cnt = 0;
   int  wrt_cnt = 0;
   int  ld_cnt = 0;
   int  spi_dly = 5;
   int  first_wrt_cyc = -1;
   int  rel_cyc = 0;
   bit  abort = 1'b0;
   bit  spur_on_wrt = 1'b0;
   bit  txn_odd = 1'b0;

   logic [15:0] cmd_q[$];
   logic [15:0] rd_q[$];
   logic [11:0] exp_q[$];
   int          ld_times[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc = cyc + 1;

   // Command scoreboard and ld_vld recorder
   always @(negedge clk) begin
      if (rst_n && spi_wrt === 1'b1) begin
         wrt_cnt++;
         if (first_wrt_cyc < 0) first_wrt_cyc = cyc;
         chk("spi_cmd", {16'h0000, spi_cmd},
             (cmd_q.size() != 0) ? {16'h0000, cmd_q.pop_front()} : 32'hFFFF_FFFF);
      end
      if (ld_vld === 1'b1) begin
         ld_cnt++;
         ld_times.push_back(cyc);
      end
   end

   // SPI monarch model: odd transactions of each pair return conversion data
   always begin : spi_model
      int d;
      @(negedge clk);
      if (abort) txn_odd = 1'b0;
      else if (rst_n && spi_wrt === 1'b1) begin
         if (spur_on_wrt) begin
            spi_rd = 16'hFFFF;
            spi_done = 1'b1;
            @(negedge clk);
            spi_done = 1'b0;
            spi_rd = 16'h0000;
         end
         d = spi_dly;
         while (d > 0 && !abort) begin
            @(negedge clk);
            d--;
         end
         if (!abort) begin
            if (txn_odd) spi_rd = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hEEEE;
            else         spi_rd = 16'h5A5A;
            spi_done = 1'b1;
            @(negedge clk);
            spi_done = 1'b0;
            spi_rd   = 16'h0000;
            txn_odd  = ~txn_odd;
            done_cnt++;
         end
      end
   end

   task automatic push_round(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
      cmd_q.push_back(16'h0000); cmd_q.push_back(16'h0000);
      cmd_q.push_back(16'h2000); cmd_q.push_back(16'h2000);
      cmd_q.push_back(16'h2800); cmd_q.push_back(16'h2800);
      cmd_q.push_back(16'h3000); cmd_q.push_back(16'h3000);
      rd_q.push_back(w0); rd_q.push_back(w1); rd_q.push_back(w2); rd_q.push_back(w3);
      exp_q.push_back(w0[11:0]); exp_q.push_back(w1[11:0]);
      exp_q.push_back(w2[11:0]); exp_q.push_back(w3[11:0]);
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done_cnt), 32'(target));
   endtask

   task automatic check_outputs(input string tag);
      repeat (3) @(negedge clk);
      chk({tag, "_lft"},   32'(lft_ld),    32'(exp_q.pop_front()));
      chk({tag, "_rght"},  32'(rght_ld),   32'(exp_q.pop_front()));
      chk({tag, "_steer"}, 32'(steer_pot), 32'(exp_q.pop_front()));
      chk({tag, "_batt"},  32'(batt),      32'(exp_q.pop_front()));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_wrt"},   32'(spi_wrt),   32'd0);
      chk({tag, "_cmd"},   32'(spi_cmd),   32'd0);
      chk({tag, "_lft"},   32'(lft_ld),    32'd0);
      chk({tag, "_rght"},  32'(rght_ld),   32'd0);
      chk({tag, "_steer"}, 32'(steer_pot), 32'd0);
      chk({tag, "_batt"},  32'(batt),      32'd0);
      chk({tag, "_ldvld"}, 32'(ld_vld),    32'd0);
      chk({tag, "_ovr"},   32'(ovr),       32'd0);
   endtask

   initial begin : main
      int base;
      int n;
      repeat (3) @(negedge clk);
      check_zero("reset");

      // Nominal round
      push_round(16'hA123, 16'hB456, 16'hC789, 16'hDABC);
      rst_n = 1'b1;
      rel_cyc = cyc;
      wait_done(8, 2000, "nominal_done");
      chk("first_start", 32'(first_wrt_cyc - rel_cyc), 32'd1025);
      check_outputs("nominal");
      chk("nominal_ldcnt", 32'(ld_cnt), 32'd1);
      chk("nominal_ovr", 32'(ovr), 32'd0);

      // Stray done while idle
      spi_rd = 16'hFFFF;
      spi_done = 1'b1;
      @(negedge clk);
      spi_done = 1'b0;
      spi_rd = 16'h0000;
      repeat (3) @(negedge clk);
      chk("idle_done_lft",  32'(lft_ld),  32'h123);
      chk("idle_done_batt", 32'(batt),    32'hABC);
      chk("idle_done_wrt",  32'(wrt_cnt), 32'd8);

      // Back-to-back rounds with stray done in every wrt cycle
      spur_on_wrt = 1'b1;
      ld_times.delete();
      for (int r = 1; r <= 3; r++)
         push_round(16'h1010 + 16'(r), 16'h2020 + 16'(r),
                    16'h3030 + 16'(r), 16'h4040 + 16'(r));
      for (int r = 1; r <= 3; r++) begin
         wait_done(8 + 8 * r, 1500, "b2b_done");
         check_outputs("b2b");
      end
      chk("b2b_ldcnt", 32'(ld_times.size()), 32'd3);
      if (ld_times.size() == 3) begin
         chk("b2b_space1", 32'(ld_times[1] - ld_times[0]), 32'd1024);
         chk("b2b_space2", 32'(ld_times[2] - ld_times[1]), 32'd1024);
      end
      chk("b2b_ovr", 32'(ovr), 32'd0);
      spur_on_wrt = 1'b0;

      // Slow SPI: round overruns several periods
      spi_dly = 1100;
      push_round(16'h15A1, 16'h25A2, 16'h35A3, 16'h45A4);
      wait_done(40, 12000, "slow_done");
      spi_dly = 20;
      push_round(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      check_outputs("slow");
      chk("slow_ovr", 32'(ovr), 32'd1);
      chk("slow_ldcnt", 32'(ld_cnt), 32'd5);
      chk("slow_wrtcnt", 32'(wrt_cnt), 32'd40);

      // Mid-round reset during steer conversion
      base = wrt_cnt;
      n = 0;
      while (wrt_cnt < base + 6 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("steer_conv_reached", 32'(wrt_cnt), 32'(base + 6));
      repeat (5) @(negedge clk);
      abort = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      cmd_q.delete();
      rd_q.delete();
      exp_q.delete();
      check_zero("midrst");
      rst_n = 1'b1;
      rel_cyc = cyc;
      first_wrt_cyc = -1;
      @(negedge clk);
      abort = 1'b0;
      spi_rd = 16'hFFFF;
      spi_done = 1'b1;
      @(negedge clk);
      spi_done = 1'b0;
      spi_rd = 16'h0000;
      repeat (2) @(negedge clk);
      chk("post_rst_done_lft",  32'(lft_ld),  32'd0);
      chk("post_rst_done_rght", 32'(rght_ld), 32'd0);
      base = done_cnt;
      push_round(16'h0765, 16'h0876, 16'h0987, 16'h0A98);
      wait_done(base + 8, 2000, "post_rst_done");
      chk("post_rst_start", 32'(first_wrt_cyc - rel_cyc), 32'd1025);
      check_outputs("post_rst");
      chk("post_rst_ovr", 32'(ovr), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
